// File: rtl/fpu_f32_pkg.sv
// Shared binary32 types, constants and operand classifiers for the F32 units.
// Classifiers treat denormals as zero.
package fpu_f32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } f32_t;

    localparam int          F32_BIAS    = 127;
    localparam logic [31:0] F32_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  F32_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StOut} mul_state_e;

    function automatic logic is_zero(f32_t x);
        return x.exp == 8'h00;
    endfunction

    function automatic logic is_inf(f32_t x);
        return (x.exp == F32_EXP_MAX) && (x.man == '0);
    endfunction

    function automatic logic is_nan(f32_t x);
        return (x.exp == F32_EXP_MAX) && (x.man != '0);
    endfunction

endpackage

// File: rtl/fpu_f32_norm_round.sv
// Normalises a 48-bit mantissa product, rounds to nearest even and packs a binary32
// result, saturating to Inf on overflow and flushing to zero on underflow.
module fpu_f32_norm_round
    import fpu_f32_pkg::*;
(
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,
    input  logic              sign,
    output logic [31:0]       result
);

    logic [22:0]       man;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       man_rnd;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    f32_t              res;

    always_comb begin
        if (prod[47]) begin
            man    = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_in + 10'sd1;
        end else begin
            man    = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_in;
        end
        round_up = guard & (sticky | man[0]);
        man_rnd  = {1'b0, man} + 24'(round_up);
        // A rounding carry leaves man_rnd[22:0] at zero, which is the wanted mantissa.
        exp_r    = man_rnd[23] ? exp_n + 10'sd1 : exp_n;

        res.sign = sign;
        res.exp  = exp_r[7:0];
        res.man  = man_rnd[22:0];
        if (exp_r >= 10'sd255) begin
            res.exp = F32_EXP_MAX;
            res.man = '0;
        end else if (exp_r <= 10'sd0) begin
            res.exp = '0;
            res.man = '0;
        end
        result = res;
    end

endmodule

// File: rtl/fpu_f32_mul_seq.sv
// Multi-cycle binary32 multiplier using an iterative shift-add mantissa datapath.
// Define FPU_F32_MUL_SEQ_RADIX4_EN to retire two multiplier bits per cycle.
module fpu_f32_mul_seq
    import fpu_f32_pkg::*;
#(
    parameter int BIAS  = F32_BIAS,
    parameter int MUL_W = 24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] O
);

`ifdef FPU_F32_MUL_SEQ_RADIX4_EN
    localparam int StepBits = 2;
`else
    localparam int StepBits = 1;
`endif
    localparam logic [4:0] LastStep = 5'(MUL_W / StepBits - 1);

    mul_state_e         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*MUL_W-1:0] acc_q, acc_d, acc_step;
    logic [MUL_W-1:0]   mcand_q, mcand_d, man_a, acc_hi;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [31:0]        special_q, special_d;
    logic [31:0]        o_q, o_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        norm_res;

    f32_t        a_f, b_f;
    logic        op_sign, res_nan, res_inf, res_zero;
    logic [31:0] special_res;

    assign a_f     = A;
    assign b_f     = B;
    assign op_sign = A[31] ^ B[31];
    assign res_nan = is_nan(a_f) | is_nan(b_f) | (is_inf(a_f) & is_zero(b_f)) |
                     (is_zero(a_f) & is_inf(b_f));
    assign res_inf  = is_inf(a_f) | is_inf(b_f);
    assign res_zero = is_zero(a_f) | is_zero(b_f);
    assign special_res = res_nan ? F32_QNAN :
                         res_inf ? {op_sign, F32_EXP_MAX, 23'h0} : {op_sign, 31'h0};

    assign man_a  = {1'b1, A[22:0]};
    assign acc_hi = acc_q[2*MUL_W-1:MUL_W];

    // Accumulator holds {partial product, unconsumed multiplier bits}; each step adds
    // into the upper half and shifts the whole register right.
`ifdef FPU_F32_MUL_SEQ_RADIX4_EN
    logic [MUL_W+1:0] mcand3_q, mcand3_d, addend, step_sum;

    always_comb begin
        unique case (acc_q[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, mcand_q};
            2'd2:    addend = {1'b0, mcand_q, 1'b0};
            default: addend = mcand3_q;
        endcase
    end
    assign step_sum = {2'b00, acc_hi} + addend;
    assign acc_step = {step_sum, acc_q[MUL_W-1:2]};
    assign mcand3_d = (state_q == StIdle) ? {2'b00, man_a} + {1'b0, man_a, 1'b0} : mcand3_q;

    always_ff @(posedge CLK) begin
        if (RST) mcand3_q <= '0;
        else     mcand3_q <= mcand3_d;
    end
`else
    logic [MUL_W:0] step_sum;

    assign step_sum = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {step_sum, acc_q[MUL_W-1:1]};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        special_d   = special_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    sign_d = op_sign;
                    if (res_nan | res_inf | res_zero) begin
                        special_d = special_res;
                        state_d   = StOut;
                    end else begin
                        mcand_d = man_a;
                        acc_d   = {{MUL_W{1'b0}}, 1'b1, B[22:0]};
                        exp_d   = {2'b00, A[30:23]} + {2'b00, B[30:23]} - 10'(BIAS);
                        cnt_d   = '0;
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LastStep) state_d = StNorm;
            end
            StNorm: begin
                o_d         = norm_res;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                // Special results arrive with valid low and are published one cycle later.
                if (!out_valid_q) begin
                    o_d         = special_q;
                    out_valid_d = 1'b1;
                end else if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            special_q   <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            special_q   <= special_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    fpu_f32_norm_round u_norm_round (
        .prod   (acc_q),
        .exp_in (exp_q),
        .sign   (sign_q),
        .result (norm_res)
    );

    assign IN_READY  = (state_q == StIdle);
    assign OUT_VALID = out_valid_q;
    assign O         = o_q;

endmodule

// File: tb/tb_fpu_f32_mul_seq.sv
// Randomised self-checking bench for fpu_f32_mul_seq against a behavioural F32 model.
module tb_fpu_f32_mul_seq;

`ifdef FPU_F32_MUL_SEQ_RADIX4_EN
    localparam int NormLat = 13;
`else
    localparam int NormLat = 25;
`endif

    logic        CLK = 1'b0;
    logic        RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [31:0] A, B, O;

    int n_total = 0;
    int n_pass  = 0;

    fpu_f32_mul_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .O         (O)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: exact integer product, normalise, round half to even by remainder.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output bit special);
        int ea, eb, e, sh;
        bit s, za, zb, ia, ib, na, nb;
        longint unsigned p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        special = 1'b1;
        res = '0;
        if (na || nb || (ia && zb) || (za && ib)) res = 32'h7FC00000;
        else if (ia || ib) res = {s, 8'hFF, 23'h0};
        else if (za || zb) res = {s, 31'h0};
        else begin
            special = 1'b0;
            p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            e  = ea + eb - 127;
            sh = (p >= (64'd1 << 47)) ? 24 : 23;
            if (sh == 24) e++;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) res = {s, 8'hFF, 23'h0};
            else if (e <= 0) res = {s, 31'h0};
            else res = {s, 8'(e), q[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_f32();
        logic [7:0]  e;
        logic [22:0] m;
        int          sel;
        sel = $urandom_range(0, 9);
        m   = 23'($urandom);
        if ($urandom_range(0, 5) == 0) m = '0;
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 30));
            3:       e = 8'($urandom_range(220, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that completes the transfer.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_o,
                          input int exp_lat, input int hold, input string tag);
        int  lat;
        bit  busy_ok, hold_ok;
        A = a;
        B = b;
        IN_VALID = 1'b1;
        lat = 0;
        while (!IN_READY && lat < 50) begin
            @(posedge CLK); #1;
            lat++;
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = $urandom;
        B = $urandom;
        busy_ok = 1'b1;
        lat = 0;
        while (!OUT_VALID && lat < 100) begin
            if (IN_READY) busy_ok = 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
        if (!OUT_VALID) begin
            check_eq({tag, " timeout"}, 32'(OUT_VALID), 32'd1);
            return;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " in_ready_low"}, 32'(busy_ok), 32'd1);
        check_eq({tag, " result"}, O, exp_o);
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (O !== exp_o || !OUT_VALID || IN_READY) hold_ok = 1'b0;
        end
        if (hold > 0) check_eq({tag, " hold_stable"}, 32'(hold_ok), 32'd1);
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check_eq({tag, " valid_drop"}, 32'(OUT_VALID), 32'd0);
        check_eq({tag, " ready_back"}, 32'(IN_READY), 32'd1);
        check_eq({tag, " o_held"}, O, exp_o);
    endtask

    logic [31:0] dir_a   [10] = '{32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h7F800000,
                                  32'hFF800000, 32'h00000001, 32'h7F000000, 32'h00800000,
                                  32'h80800000, 32'h7F800001};
    logic [31:0] dir_b   [10] = '{32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h00000000,
                                  32'h40000000, 32'h3F800000, 32'h7F000000, 32'h00800000,
                                  32'h00800000, 32'h3F800000};
    logic [31:0] dir_o   [10] = '{32'h40C00000, 32'h3F800002, 32'h40100000, 32'h7FC00000,
                                  32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000,
                                  32'h80000000, 32'h7FC00000};
    bit          dir_spc [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, ro;
        bit          rs;
        bit          quiet;
        RST = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_eq("reset in_ready", 32'(IN_READY), 32'd1);
        check_eq("reset out_valid", 32'(OUT_VALID), 32'd0);
        check_eq("reset o", O, 32'h0);

        for (int i = 0; i < 10; i++)
            run_op(dir_a[i], dir_b[i], dir_o[i], dir_spc[i] ? 1 : NormLat, (i == 0) ? 5 : 0,
                   $sformatf("dir%0d", i));

        // Reset during MUL discards the operation.
        A = 32'h40000000;
        B = 32'h40400000;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_eq("midreset out_valid", 32'(OUT_VALID), 32'd0);
        check_eq("midreset in_ready", 32'(IN_READY), 32'd1);
        check_eq("midreset o", O, 32'h0);
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID || !IN_READY) quiet = 1'b0;
        end
        check_eq("midreset no_stale", 32'(quiet), 32'd1);
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, NormLat, 0, "post_reset");

        for (int i = 0; i < 40; i++) begin
            ra = rand_f32();
            rb = rand_f32();
            ref_mul(ra, rb, ro, rs);
            run_op(ra, rb, ro, rs ? 1 : NormLat, $urandom_range(0, 2),
                   $sformatf("rnd%0d a=%h b=%h", i, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_f32_mul_seq.md
Name: fpu_f32_mul_seq

Overview:
Multi-cycle IEEE-754 binary32 multiplier, the multiplicative counterpart of the FPU divide unit. Uses an iterative shift-add mantissa datapath with valid/ready handshakes on both sides. Sits in the FPU cluster beside the other F32 units, for area-constrained configurations where a combinational multiplier is too large.

Parameters:
BIAS, 127, exponent bias; fixed for binary32 and not to be overridden.
MUL_W, 24, mantissa width including the hidden bit.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  reset; synchronous, active-high.
IN_VALID  input  1  operands A and B are valid.
IN_READY  output  1  unit accepts operands (high only in IDLE).
A  input  32  multiplicand, F32.
B  input  32  multiplier, F32.
OUT_VALID  output  1  result O is valid.
OUT_READY  input  1  consumer accepts O.
O  output  32  product, F32.

Behaviour:
- Reset (RST=1 at an edge): state to IDLE, OUT_VALID=0, O=32'h0, counter=0. IN_READY=1 in the following cycle. Reset wins over any handshake at the same edge.
- Reset mid-operation: any in-flight operation is discarded and no result is produced.
- FSM states: IDLE, MUL, NORM, OUT.
- IDLE: IN_READY=1. Accept at edge k when IN_VALID=1. Latch sign = A[31]^B[31]. Classify operands:
  - Denormal inputs are flushed to signed zero before classification.
  - NaN operand, or Inf×0 → special result 32'h7FC00000 (canonical qNaN, sign ignored).
  - Inf×finite-nonzero → {sign, 8'hFF, 23'h0}.
  - Zero×finite → {sign, 31'h0}.
  - Special case: go directly to OUT; OUT_VALID=1 after edge k+1.
  - Otherwise go to MUL. Load mantissas {1,frac}. Exponent sum = ea+eb−BIAS, 10-bit signed.
- MUL: one multiplier bit per cycle, LSB first. The 48-bit accumulator adds the multiplicand when the bit is 1, then shifts. Runs 24 cycles (edges k+1..k+24), then goes to NORM.
- NORM (one cycle, edge k+25):
  - If product[47]=1, take mantissa from [46:24] and increment exponent; else take [45:23].
  - Round to nearest even using guard and sticky bits (all lower bits ORed).
  - Mantissa carry-out after rounding → exponent +1, mantissa zero.
  - Final exponent ≥255 → signed Inf. Exponent ≤0 → signed zero (no denormal output).
  - Go to OUT; OUT_VALID=1 after edge k+25.
- OUT: O and OUT_VALID are held stable until OUT_READY=1. On that edge, OUT_VALID→0 and state→IDLE, so the next accept is possible one edge later.
- IN_READY=0 in MUL, NORM and OUT. There is no overlap between operations.
- O holds its last value while OUT_VALID=0.

Optional Feature:
FPU_F32_MUL_SEQ_RADIX4_EN
- Defined: 2 multiplier bits per cycle, with a 0/1/2/3× multiplicand add (3× precomputed at accept). MUL lasts 12 cycles; normal-path OUT_VALID after edge k+13.
- Undefined: radix-2, 24 MUL cycles, OUT_VALID after edge k+25.
- Results are bit-identical in both modes. Special-case latency is unchanged.

Decomposition:
- Shared package fpu_f32_pkg holds:
  - typedef f32_t struct {sign; exp[7:0]; man[22:0]}.
  - Constants F32_BIAS=127, F32_QNAN=32'h7FC00000, F32_EXP_MAX=8'hFF.
  - Classify helpers is_nan/is_inf/is_zero, with denormals treated as zero.
- One combinational sub-module, fpu_f32_norm_round:
  - Inputs: 48-bit product, 10-bit signed exponent, sign.
  - Output: packed F32 result.
  - Reusable by later F32 units.

Test Plan:
- A=32'h40000000, B=32'h40400000 → O=32'h40C00000, OUT_VALID exactly 25 cycles after accept (13 with RADIX4_EN), IN_READY=0 throughout.
- A=32'h3F800001, B=32'h3F800001 → O=32'h3F800002 (round-to-nearest-even, sticky set). A=32'h3FC00000, B=32'h3FC00000 → O=32'h40100000.
- Specials:
  - A=32'h7F800000, B=32'h00000000 → O=32'h7FC00000 one cycle after accept.
  - A=32'hFF800000, B=32'h40000000 → O=32'hFF800000.
  - A=32'h00000001 (denormal), B=32'h3F800000 → O=32'h00000000.
- Overflow/underflow:
  - A=B=32'h7F000000 → O=32'h7F800000.
  - A=B=32'h00800000 → O=32'h00000000.
  - A=32'h80800000, B=32'h00800000 → O=32'h80000000.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID rises → O and OUT_VALID stable, IN_READY=0. The OUT_READY pulse completes the transfer, and IN_READY=1 on the next cycle.
- Reset: assert RST at MUL cycle 10 → OUT_VALID=0 and IN_READY=1 the cycle after reset release, no stale result. A fresh 2.0×3.0 then returns 32'h40C00000 with nominal latency.
